// File: rtl/mbf_pkg.sv
// -----------------------------------------------------------------------------
// mbf_pkg
// Shared types and defaults for the multi-bank filter tap scheduler.
//   state_t        : scheduler phase (INIT sweep, IDLE, LPF taps, HPF taps, STOP)
//   BANK_LPF/HPF   : coefficient ROM bank select (MSB of coef_addr)
//   DEF_*          : default filter geometry and run length
// -----------------------------------------------------------------------------
package mbf_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LPF,
    HPF,
    STOP
  } state_t;

  localparam logic BANK_LPF = 1'b0;
  localparam logic BANK_HPF = 1'b1;

  localparam int DEF_TAPS      = 32;
  localparam int DEF_MAC_LAT   = 2;
  localparam int DEF_N_SAMPLES = 527;

endpackage

// File: rtl/mbf_tap_scheduler_if.sv
// -----------------------------------------------------------------------------
// mbf_tap_scheduler_if
// Bundles the sample handshake, history RAM port, coefficient/MAC control and
// result strobes of the tap scheduler.
//   master : the scheduler (consumes x_valid/x, drives everything else)
//   slave  : the surrounding datapath / sample producer
// -----------------------------------------------------------------------------
interface mbf_tap_scheduler_if #(
  parameter int AW = 5
);

  logic          x_valid;
  logic [7:0]    x;
  logic          x_ready;
  logic          hist_we;
  logic [AW-1:0] hist_waddr;
  logic [7:0]    hist_wdata;
  logic [AW-1:0] hist_raddr;
  logic [AW:0]   coef_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          y_latch;
  logic          z_latch;
  logic          done;

  modport master (
    input  x_valid, x,
    output x_ready, hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr,
           mac_en, mac_clr, y_latch, z_latch, done
  );

  modport slave (
    output x_valid, x,
    input  x_ready, hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr,
           mac_en, mac_clr, y_latch, z_latch, done
  );

endinterface

// File: rtl/mbf_pulse_delay.sv
// -----------------------------------------------------------------------------
// mbf_pulse_delay
// Delays a single-bit strobe by exactly DEPTH clock cycles.
//   clk  : clock
//   clr  : synchronous clear, active high; flushes any pulse in flight
//   din  : strobe in
//   dout : strobe out, DEPTH cycles after din
// -----------------------------------------------------------------------------
module mbf_pulse_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  // NOTE: the delay line is cleared because a stale pulse surviving a reset
  // would fire a result strobe for a sample that was never completed.
  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mbf_tap_scheduler.sv
// -----------------------------------------------------------------------------
// mbf_tap_scheduler
// Sequences one shared MAC and coefficient ROM across the LPF (y) and HPF (z)
// banks. Each accepted sample is written into a circular history RAM, then
// TAPS LPF taps and TAPS HPF taps are issued, newest sample first.
//   clk   : clock
//   reset : synchronous, active low
//   bus   : sample handshake, history RAM, coefficient/MAC control, strobes
// hist_raddr/coef_addr/mac_en/mac_clr are registered; the INIT/IDLE write port
// and x_ready are decoded from the current state.
// -----------------------------------------------------------------------------
module mbf_tap_scheduler
  import mbf_pkg::*;
#(
  parameter int TAPS      = DEF_TAPS,
  parameter int AW        = $clog2(TAPS),
  parameter int MAC_LAT   = DEF_MAC_LAT,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input logic                 clk,
  input logic                 reset,
  mbf_tap_scheduler_if.master bus
);

  localparam int            SW   = $clog2(N_SAMPLES + 1);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t        state, state_nxt;
  logic          run;  // low for the first cycle after reset so INIT starts clean
  logic [AW-1:0] init_cnt, init_nxt;
  logic [AW-1:0] tap_cnt, tap_nxt;
  logic [AW-1:0] wr_ptr, wr_nxt;
  logic [AW-1:0] newest, newest_nxt;
  logic [SW-1:0] smp_cnt, smp_nxt;
  logic          busy_nxt;
  logic          y_fin, z_fin;
  logic          y_latch, z_latch;
  logic          done_q, done_w;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    init_nxt   = init_cnt;
    tap_nxt    = tap_cnt;
    wr_nxt     = wr_ptr;
    newest_nxt = newest;
    smp_nxt    = smp_cnt;
    unique case (state)
      INIT: if (run) begin
        init_nxt = init_cnt + 1'b1;
        if (init_cnt == LAST) state_nxt = IDLE;
      end
      IDLE: if (bus.x_valid) begin
        newest_nxt = wr_ptr;
        wr_nxt     = wr_ptr + 1'b1;
        tap_nxt    = '0;
        state_nxt  = LPF;
      end
      LPF: begin
        // TAPS is a power of two, so the tap counter wraps to 0 for HPF.
        tap_nxt = tap_cnt + 1'b1;
        if (tap_cnt == LAST) state_nxt = HPF;
      end
      HPF: begin
        tap_nxt = tap_cnt + 1'b1;
        if (tap_cnt == LAST) begin
          smp_nxt   = smp_cnt + 1'b1;
          state_nxt = (smp_cnt + 1'b1 == SW'(N_SAMPLES)) ? STOP : IDLE;
        end
      end
      STOP: ;
      default: state_nxt = INIT;
    endcase
  end

  assign busy_nxt = (state_nxt == LPF) || (state_nxt == HPF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= INIT;
      run            <= 1'b0;
      init_cnt       <= '0;
      tap_cnt        <= '0;
      wr_ptr         <= '0;
      newest         <= '0;
      smp_cnt        <= '0;
      bus.mac_en     <= 1'b0;
      bus.mac_clr    <= 1'b0;
      bus.hist_raddr <= '0;
      bus.coef_addr  <= '0;
      y_fin          <= 1'b0;
      z_fin          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state          <= state_nxt;
      run            <= 1'b1;
      init_cnt       <= init_nxt;
      tap_cnt        <= tap_nxt;
      wr_ptr         <= wr_nxt;
      newest         <= newest_nxt;
      smp_cnt        <= smp_nxt;
      // Tap addresses are computed from next-state values so they appear in
      // the same cycle as mac_en; AW-bit subtraction gives the circular wrap.
      bus.mac_en     <= busy_nxt;
      bus.mac_clr    <= busy_nxt && (tap_nxt == '0);
      bus.hist_raddr <= newest_nxt - tap_nxt;
      bus.coef_addr  <= {(state_nxt == HPF) ? BANK_HPF : BANK_LPF, tap_nxt};
      y_fin          <= (state_nxt == LPF) && (tap_nxt == LAST);
      z_fin          <= (state_nxt == HPF) && (tap_nxt == LAST);
      done_q         <= done_w;
    end
  end

  // Final-tap strobes delayed by the MAC pipeline depth.
  mbf_pulse_delay #(.DEPTH(MAC_LAT)) u_y_dly (
    .clk  (clk),
    .clr  (!reset),
    .din  (y_fin),
    .dout (y_latch)
  );

  mbf_pulse_delay #(.DEPTH(MAC_LAT)) u_z_dly (
    .clk  (clk),
    .clr  (!reset),
    .din  (z_fin),
    .dout (z_latch)
  );

  // The last HPF strobe always lands once the FSM has parked in STOP.
  assign done_w = done_q || (z_latch && (state == STOP));

  assign bus.x_ready    = (state == IDLE);
  assign bus.hist_we    = ((state == INIT) && run) || ((state == IDLE) && bus.x_valid);
  assign bus.hist_waddr = (state == INIT) ? init_cnt : wr_ptr;
  assign bus.hist_wdata = (state == IDLE) ? bus.x : 8'h00;
  assign bus.y_latch    = y_latch;
  assign bus.z_latch    = z_latch;
  assign bus.done       = done_w;

endmodule

// File: tb/tb_mbf_tap_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mbf_tap_scheduler
// Directed bench for mbf_tap_scheduler. A cycle-level model derives expected
// outputs from the handshake history (sample count, cycles since handshake)
// and is compared against the DUT on every cycle; directed phases add literal
// expectations for reset/INIT, a single sample, mid-LPF reset and a full run.
// -----------------------------------------------------------------------------
module tb_mbf_tap_scheduler;
  import mbf_pkg::*;

  localparam int T  = 32;
  localparam int AW = 5;
  localparam int L  = 2;
  localparam int N  = 527;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mbf_tap_scheduler_if #(.AW(AW)) bus ();

  mbf_tap_scheduler #(
    .TAPS(T), .AW(AW), .MAC_LAT(L), .N_SAMPLES(N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mrun      = 1'b0;
  int init_c0   = 0;
  int hs_q[$];            // cycle of every handshake since the last reset
  bit exp_ready = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mrun = 1'b0;
      hs_q.delete();
    end else if (!mrun) begin
      mrun    = 1'b1;
      init_c0 = cyc;
    end else if (exp_ready && bus.x_valid) begin
      hs_q.push_back(cyc - 1);
    end
  end

  logic e_we, e_rdy, e_mac, e_clr, e_y, e_z, e_done;
  int   e_waddr, e_wdata, e_raddr, e_coef;

  always @(negedge clk) begin
    int n, d, k, i;
    e_we = 0; e_rdy = 0; e_mac = 0; e_clr = 0; e_y = 0; e_z = 0; e_done = 0;
    e_waddr = 0; e_wdata = 0; e_raddr = 0; e_coef = 0;
    if (mrun) begin
      i = cyc - init_c0;
      if (i < T) begin
        e_we    = 1;
        e_waddr = i;
      end else begin
        n = hs_q.size();
        d = (n > 0) ? cyc - hs_q[n-1] : 1 << 30;
        if (d >= 1 && d <= 2 * T) begin
          k       = (d - 1) % T;
          e_mac   = 1;
          e_clr   = (k == 0);
          e_raddr = (((n - 1 - k) % T) + T) % T;
          e_coef  = (d <= T) ? k : T + k;
        end else begin
          e_rdy = (n < N);
        end
        if (e_rdy) begin
          e_we    = bus.x_valid;
          e_waddr = n % T;
          e_wdata = bus.x;
        end
        for (int j = (n > 2) ? n - 2 : 0; j < n; j++) begin
          if (cyc - hs_q[j] == T + L)     e_y = 1;
          if (cyc - hs_q[j] == 2 * T + L) e_z = 1;
        end
        e_done = (n == N) && (d >= 2 * T + L);
      end
    end
    exp_ready = e_rdy;
    if (cyc > 0) begin
      check("x_ready", bus.x_ready, e_rdy);
      check("hist_we", bus.hist_we, e_we);
      if (e_we || !mrun) begin
        check("hist_waddr", bus.hist_waddr, e_waddr);
        check("hist_wdata", bus.hist_wdata, e_wdata);
      end
      check("mac_en", bus.mac_en, e_mac);
      check("mac_clr", bus.mac_clr, e_clr);
      if (e_mac || !mrun) begin
        check("hist_raddr", bus.hist_raddr, e_raddr);
        check("coef_addr", bus.coef_addr, e_coef);
      end
      check("y_latch", bus.y_latch, e_y);
      check("z_latch", bus.z_latch, e_z);
      check("done", bus.done, e_done);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from reset release until x_ready, and latch pulses seen.
  task automatic wait_ready(output int k, output int lat);
    k = 0; lat = 0;
    while (!bus.x_ready && k < 100) begin
      tick();
      k++;
      if (bus.y_latch || bus.z_latch) lat++;
      if (k == 1) begin
        check("init_first_we", bus.hist_we, 1);
        check("init_first_addr", bus.hist_waddr, 0);
      end
      if (k == T) check("init_last_addr", bus.hist_waddr, T - 1);
    end
  endtask

  initial begin
    int k, lat, lat2, t, yj, zj, yc, zc, n_hs, h1, h34, rdy_cnt, extra, lost;
    bit hs_last, done_prev;

    bus.x_valid = 1'b0;
    bus.x       = 8'h00;

    // Reset and INIT sweep
    repeat (3) tick();
    check("reset_ready", bus.x_ready, 0);
    check("reset_we", bus.hist_we, 0);
    reset = 1'b1;
    wait_ready(k, lat);
    check("ready_rise_cycle", k, T + 1);

    // Single sample 0x5A
    bus.x_valid = 1'b1;
    bus.x       = 8'h5A;
    #1;
    check("s1_we", bus.hist_we, 1);
    check("s1_waddr", bus.hist_waddr, 0);
    check("s1_wdata", bus.hist_wdata, 8'h5A);
    yj = 0; zj = 0; yc = 0; zc = 0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (j == 1) bus.x_valid = 1'b0;
      if (j == 1) begin
        check("s1_tap0_raddr", bus.hist_raddr, 0);
        check("s1_tap0_clr", bus.mac_clr, 1);
      end
      if (j == 2) begin
        check("s1_tap1_raddr", bus.hist_raddr, 31);
        check("s1_tap1_coef", bus.coef_addr, 1);
      end
      if (j == T)     check("s1_lpf_last_raddr", bus.hist_raddr, 1);
      if (j == T + 1) check("s1_hpf_first_coef", bus.coef_addr, 32);
      if (j == 2 * T) check("s1_hpf_last_coef", bus.coef_addr, 63);
      if (bus.y_latch) begin yc++; yj = j; end
      if (bus.z_latch) begin zc++; zj = j; end
    end
    check("s1_y_latch_time", yj, 34);
    check("s1_z_latch_time", zj, 66);
    check("s1_latch_counts", {yc[15:0], zc[15:0]}, {16'd1, 16'd1});

    // Second sample, reset at LPF tap 10
    bus.x_valid = 1'b1;
    bus.x       = 8'h11;
    #1;
    tick();
    bus.x_valid = 1'b0;
    repeat (10) tick();
    check("mid_tap10_coef", bus.coef_addr, 10);
    check("mid_tap10_raddr", bus.hist_raddr, 23);
    reset = 1'b0;
    lat = 0;
    repeat (3) begin
      tick();
      if (bus.y_latch || bus.z_latch) lat++;
    end
    reset = 1'b1;
    wait_ready(k, lat2);
    check("mid_ready_rise_cycle", k, T + 1);
    check("mid_no_latch", lat + lat2, 0);
    bus.x_valid = 1'b1;
    bus.x       = 8'h22;
    #1;
    check("mid_post_reset_waddr", bus.hist_waddr, 0);
    check("mid_post_reset_wdata", bus.hist_wdata, 8'h22);
    tick();
    bus.x_valid = 1'b0;
    repeat (70) tick();

    // Full run with x_valid held high
    reset = 1'b0;
    repeat (2) tick();
    reset       = 1'b1;
    bus.x_valid = 1'b1;
    bus.x       = 8'h05;
    k = 0; n_hs = 0; yc = 0; zc = 0; h1 = 0; h34 = -10;
    hs_last = 1'b0; done_prev = 1'b0;
    while (zc < N && k < 40000) begin
      tick();
      k++;
      if (hs_last) bus.x = 8'(n_hs * 37 + 5);
      hs_last = 1'b0;
      #1;
      if (bus.x_ready && bus.x_valid) begin
        n_hs++;
        hs_last = 1'b1;
        if (n_hs == 1) h1 = k;
        if (n_hs == 2) check("hs_spacing", k - h1, 2 * T + 1);
        if (n_hs == 34) begin
          check("wrap_waddr", bus.hist_waddr, 1);
          h34 = k;
        end
      end
      if (k == h34 + 2) check("wrap_tap1_raddr", bus.hist_raddr, 0);
      if (bus.y_latch) yc++;
      if (bus.z_latch) begin
        zc++;
        if (zc == N) begin
          check("done_with_last_z", bus.done, 1);
          check("done_before_last_z", done_prev, 0);
        end
      end
      done_prev = bus.done;
    end
    check("run_handshakes", n_hs, N);
    check("run_y_latch_count", yc, N);
    check("run_z_latch_count", zc, N);

    rdy_cnt = 0; extra = 0; lost = 0;
    repeat (200) begin
      tick();
      if (bus.x_ready) rdy_cnt++;
      if (bus.y_latch || bus.z_latch || bus.mac_en) extra++;
      if (!bus.done) lost++;
    end
    check("stop_ready_low", rdy_cnt, 0);
    check("stop_no_activity", extra, 0);
    check("stop_done_sticky", lost, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbf_tap_scheduler.md
# mbf_tap_scheduler

Sequencer for the multi-bank filter (MBF) datapath. It shares one external multiply-accumulate (MAC) unit and one coefficient ROM between the low-pass (LPF, `y`) and high-pass (HPF, `z`) channels. For every accepted 8-bit input sample it:
- writes the sample into a circular history RAM,
- issues TAPS LPF tap operations, then TAPS HPF tap operations,
- pulses a latch strobe per channel when that channel's MAC result is final. These strobes become `y_valid` and `z_valid` at the MBF top level.

## Interface
- `TAPS`, 32: filter length per bank; power of two, ≥ 4.
- `AW`, 5: log2(TAPS).
- `MAC_LAT`, 2: cycles from last `mac_en` to a valid accumulator output; ≥ 1.
- `N_SAMPLES`, 527: samples per run; `done` asserts after the last one.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `x_valid` in 1: input sample offered.
- `x` in 8: input sample.
- `x_ready` out 1: scheduler can accept a sample.
- `hist_we` out 1: history RAM write enable.
- `hist_waddr` out AW: history write address.
- `hist_wdata` out 8: history write data.
- `hist_raddr` out AW: history read address; RAM has a 1-cycle read.
- `coef_addr` out AW+1: coefficient address; MSB 0 = LPF bank, 1 = HPF bank.
- `mac_en` out 1: MAC consumes the current history/coefficient pair.
- `mac_clr` out 1: first tap of a channel; MAC loads the product instead of accumulating.
- `y_latch` out 1: LPF result valid at MAC output this cycle.
- `z_latch` out 1: HPF result valid at MAC output this cycle.
- `done` out 1: `N_SAMPLES` HPF results have been emitted; sticky until reset.

## Operation
- States:
  - INIT: zero-sweep of the history RAM.
  - IDLE: wait for a sample.
  - LPF: TAPS cycles, issuing LPF taps.
  - HPF: TAPS cycles, issuing HPF taps.
  - STOP: sample budget exhausted.
- Reset (`reset`=0 at an edge): state←INIT; `init_cnt`, `tap_cnt`, `wr_ptr`, `smp_cnt`←0; delay lines cleared. All outputs are 0 while reset is asserted and on the first cycle after its release.
- INIT:
  - `hist_we`=1, `hist_waddr`=`init_cnt`, `hist_wdata`=0, `x_ready`=0.
  - After `init_cnt`=TAPS−1 → IDLE.
- IDLE:
  - `x_ready`=1. `hist_we`=`x_valid`, `hist_waddr`=`wr_ptr`, `hist_wdata`=`x` (combinational).
  - On handshake: `newest`←`wr_ptr`; `wr_ptr`←`wr_ptr`+1 mod TAPS; → LPF.
- LPF, tap k (0..TAPS−1):
  - `mac_en`=1, `mac_clr`=(k==0).
  - `hist_raddr`=`newest`−k mod TAPS (wrap via AW-bit subtraction).
  - `coef_addr`={0,k}.
  - At k=TAPS−1 → HPF with k←0.
- HPF: identical to LPF with `coef_addr`={1,k}. At k=TAPS−1 → IDLE, or → STOP if `smp_cnt`+1==`N_SAMPLES`. `smp_cnt` increments at this transition.
- STOP: `x_ready`=0, no MAC activity; left only by reset.
- `x_ready`=0 in LPF, HPF, INIT and STOP; `x` is ignored there. Data offered while not ready is not lost; the producer holds it.
- `done` sets on the final `z_latch`, not at entry to STOP.

## Timing
- Handshake at cycle t:
  - LPF taps occupy t+1..t+TAPS.
  - HPF taps occupy t+TAPS+1..t+2·TAPS.
  - Earliest next handshake is t+2·TAPS+1 (x_valid held high → one sample every 2·TAPS+1 cycles).
- `y_latch` pulses exactly at t+TAPS+MAC_LAT. `z_latch` pulses at t+2·TAPS+MAC_LAT.
- Both strobes are the final-tap `mac_en` delayed MAC_LAT cycles through a shift register.
  - `y_latch` may fall inside the HPF phase; `z_latch` may overlap the next sample's LPF phase. Both are legal; the MAC shadows its result on the latch strobe.
- `hist_raddr` and `coef_addr` are registered outputs, aligned with `mac_en` in the same cycle. The MAC pipeline absorbs the RAM read latency.
- A write and a read to the same history address never coincide. Tap 0 reads `newest` one cycle after its write.
- Reset mid-LPF/HPF: pending latch pulses are discarded; no `y_latch`/`z_latch` after reset release until a new sample completes.
- After reset release, INIT takes TAPS cycles. `x_ready` first rises on cycle TAPS+1 after release.

## Structure
- Package `mbf_pkg`:
  - state enum {INIT, IDLE, LPF, HPF, STOP};
  - constants BANK_LPF=0, BANK_HPF=1;
  - default TAPS/MAC_LAT/N_SAMPLES.
- Sub-module `mbf_pulse_delay` (parameter DEPTH): shift-register delay with synchronous clear. Two instances, one for `y_latch` and one for `z_latch`.

## Test plan
- Reset, then release → `hist_we`=1 for 32 cycles with addr 0..31 and data 00; `x_ready` rises at cycle 33.
- One sample `x`=0x5A at handshake t → write to addr 0; LPF `hist_raddr` sequence 0,31,30,…,1 with `coef_addr` 0..31; HPF `coef_addr` 32..63; `y_latch` at t+34; `z_latch` at t+66.
- `x_valid` held high → handshakes exactly 65 cycles apart; `mac_clr` only on k=0 of each channel.
- 40 samples → `wr_ptr` wraps; the 34th sample is written at addr 1 and its tap-1 read is addr 0.
- Full run with `N_SAMPLES`=527 → exactly 527 `y_latch` and 527 `z_latch` pulses; `done` rises with the 527th `z_latch`; `x_ready` stays 0 afterwards.
- Reset asserted at LPF tap 10 → no latch pulses follow; INIT sweep repeats; first subsequent sample is written at addr 0.
